// File: rtl/video_dnn_seg_cls_merge.sv
// -----------------------------------------------------------------------------
// video_dnn_seg_cls_merge
//
// Purpose:
//   Joins a per-pixel classification stream with a segmentation stream coming
//   from two independent DNN paths. Class votes are gated by the segmentation
//   mask, a "not a digit" background class is appended, and the per-class
//   vote counts are reduced to the argmax class number and its vote count.
//   Two register stages, full throughput, backpressure via m_axi4s_tready.
//
// Optional build macro:
//   VIDEO_DNN_SEG_CLS_MERGE_ALIGN_CHECK_EN - when defined, a sticky
//   err_misalign flag is raised if the two streams disagree on tuser[0] or
//   tlast at a join handshake. When undefined, err_misalign is tied to 0.
//
// Ports:
//   aclk, aresetn            clock, synchronous active-low reset
//   s_cls_*                  classification stream (tdata: class c, channel k
//                            at bit c*CHANNEL_WIDTH+k), tuser/tlast forwarded
//   s_seg_*                  segmentation stream (tdata: digit-present mask,
//                            one bit per channel)
//   m_axi4s_tnumber          argmax class (NUM_CLASS = background/no votes)
//   m_axi4s_tcount           votes of argmax class, saturated
//   m_axi4s_tclustering      gated class bits, background in top bits
//   m_axi4s_tuser/tlast      sideband taken from the classification stream
//   m_axi4s_tvalid/tready    output handshake
//   err_misalign             sticky sideband mismatch flag
// -----------------------------------------------------------------------------
module video_dnn_seg_cls_merge #(
    parameter int NUM_CLASS       = 10,
    parameter int CHANNEL_WIDTH   = 1,
    parameter int TUSER_WIDTH     = 1,
    parameter int M_TNUMBER_WIDTH = 4,
    parameter int M_TCOUNT_WIDTH  = 1
) (
    input  logic                                   aclk,
    input  logic                                   aresetn,

    input  logic [TUSER_WIDTH-1:0]                 s_cls_tuser,
    input  logic                                   s_cls_tlast,
    input  logic [NUM_CLASS*CHANNEL_WIDTH-1:0]     s_cls_tdata,
    input  logic                                   s_cls_tvalid,
    output logic                                   s_cls_tready,

    input  logic [TUSER_WIDTH-1:0]                 s_seg_tuser,
    input  logic                                   s_seg_tlast,
    input  logic [CHANNEL_WIDTH-1:0]               s_seg_tdata,
    input  logic                                   s_seg_tvalid,
    output logic                                   s_seg_tready,

    output logic [TUSER_WIDTH-1:0]                 m_axi4s_tuser,
    output logic                                   m_axi4s_tlast,
    output logic [M_TNUMBER_WIDTH-1:0]             m_axi4s_tnumber,
    output logic [M_TCOUNT_WIDTH-1:0]              m_axi4s_tcount,
    output logic [(NUM_CLASS+1)*CHANNEL_WIDTH-1:0] m_axi4s_tclustering,
    output logic                                   m_axi4s_tvalid,
    input  logic                                   m_axi4s_tready,

    output logic                                   err_misalign
);

    localparam int CNT_W   = $clog2(CHANNEL_WIDTH + 1);
    localparam int CLU_W   = (NUM_CLASS + 1) * CHANNEL_WIDTH;
    localparam int SAT_MAX = (1 << M_TCOUNT_WIDTH) - 1;

    function automatic logic [CNT_W-1:0] popcnt(input logic [CHANNEL_WIDTH-1:0] v);
        logic [CNT_W-1:0] s;
        s = '0;
        for (int k = 0; k < CHANNEL_WIDTH; k++) begin
            s = s + CNT_W'(v[k]);
        end
        return s;
    endfunction

    // Counts stay full width internally; only the output port is clipped.
    function automatic logic [M_TCOUNT_WIDTH-1:0] sat_count(input logic [CNT_W-1:0] v);
        if (int'(v) > SAT_MAX) begin
            return '1;
        end
        return M_TCOUNT_WIDTH'(v);
    endfunction

    logic st1_accept;
    logic st2_accept;
    logic join_hs;

    logic                   vld_p1_q,  vld_p1_d;
    logic [TUSER_WIDTH-1:0] user_p1_q, user_p1_d;
    logic                   last_p1_q, last_p1_d;
    logic [CLU_W-1:0]       clu_p1_q,  clu_p1_d;

    logic                       vld_p2_q,  vld_p2_d;
    logic [TUSER_WIDTH-1:0]     user_p2_q, user_p2_d;
    logic                       last_p2_q, last_p2_d;
    logic [M_TNUMBER_WIDTH-1:0] num_p2_q,  num_p2_d;
    logic [M_TCOUNT_WIDTH-1:0]  cnt_p2_q,  cnt_p2_d;
    logic [CLU_W-1:0]           clu_p2_q,  clu_p2_d;

    logic [CLU_W-1:0]           gated;
    logic [CNT_W-1:0]           cur_cnt;
    logic [CNT_W-1:0]           best_cnt;
    logic [M_TNUMBER_WIDTH-1:0] best_idx;

    // Segmentation sideband is only inspected by the optional align check.
    logic unused_seg_side;
    assign unused_seg_side = ^{s_seg_tuser, s_seg_tlast};

    assign st2_accept = !vld_p2_q || m_axi4s_tready;
    assign st1_accept = !vld_p1_q || st2_accept;

    // Each ready depends on the other side's valid so neither stream is
    // consumed on its own.
    assign join_hs      = s_cls_tvalid && s_seg_tvalid && st1_accept;
    assign s_cls_tready = s_seg_tvalid && st1_accept;
    assign s_seg_tready = s_cls_tvalid && st1_accept;

    // ---- join -> stage 1: mask gating and background class ----
    always_comb begin
        gated = '0;
        for (int c = 0; c < NUM_CLASS; c++) begin
            gated[c*CHANNEL_WIDTH +: CHANNEL_WIDTH] =
                s_cls_tdata[c*CHANNEL_WIDTH +: CHANNEL_WIDTH] & s_seg_tdata;
        end
        gated[NUM_CLASS*CHANNEL_WIDTH +: CHANNEL_WIDTH] = ~s_seg_tdata;
    end

    always_comb begin
        vld_p1_d  = vld_p1_q;
        user_p1_d = user_p1_q;
        last_p1_d = last_p1_q;
        clu_p1_d  = clu_p1_q;
        if (st1_accept) begin
            vld_p1_d = join_hs;
            if (join_hs) begin
                user_p1_d = s_cls_tuser;
                last_p1_d = s_cls_tlast;
                clu_p1_d  = gated;
            end
        end
    end

    // ---- stage 1 -> stage 2: vote counts and argmax ----
    // Strict '>' while scanning upward keeps the lowest index on ties; the
    // background index is the default so an all-zero beat reports NUM_CLASS.
    always_comb begin
        cur_cnt  = '0;
        best_cnt = '0;
        best_idx = M_TNUMBER_WIDTH'(NUM_CLASS);
        for (int c = 0; c <= NUM_CLASS; c++) begin
            cur_cnt = popcnt(clu_p1_q[c*CHANNEL_WIDTH +: CHANNEL_WIDTH]);
            if (cur_cnt > best_cnt) begin
                best_cnt = cur_cnt;
                best_idx = M_TNUMBER_WIDTH'(c);
            end
        end
    end

    always_comb begin
        vld_p2_d  = vld_p2_q;
        user_p2_d = user_p2_q;
        last_p2_d = last_p2_q;
        num_p2_d  = num_p2_q;
        cnt_p2_d  = cnt_p2_q;
        clu_p2_d  = clu_p2_q;
        if (st2_accept) begin
            vld_p2_d = vld_p1_q;
            if (vld_p1_q) begin
                user_p2_d = user_p1_q;
                last_p2_d = last_p1_q;
                num_p2_d  = best_idx;
                cnt_p2_d  = sat_count(best_cnt);
                clu_p2_d  = clu_p1_q;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            vld_p1_q  <= 1'b0;
            user_p1_q <= '0;
            last_p1_q <= 1'b0;
            clu_p1_q  <= '0;
            vld_p2_q  <= 1'b0;
            user_p2_q <= '0;
            last_p2_q <= 1'b0;
            num_p2_q  <= '0;
            cnt_p2_q  <= '0;
            clu_p2_q  <= '0;
        end else begin
            vld_p1_q  <= vld_p1_d;
            user_p1_q <= user_p1_d;
            last_p1_q <= last_p1_d;
            clu_p1_q  <= clu_p1_d;
            vld_p2_q  <= vld_p2_d;
            user_p2_q <= user_p2_d;
            last_p2_q <= last_p2_d;
            num_p2_q  <= num_p2_d;
            cnt_p2_q  <= cnt_p2_d;
            clu_p2_q  <= clu_p2_d;
        end
    end

    // ---- stage 2 -> output ----
    assign m_axi4s_tvalid      = vld_p2_q;
    assign m_axi4s_tuser       = user_p2_q;
    assign m_axi4s_tlast       = last_p2_q;
    assign m_axi4s_tnumber     = num_p2_q;
    assign m_axi4s_tcount      = cnt_p2_q;
    assign m_axi4s_tclustering = clu_p2_q;

`ifdef VIDEO_DNN_SEG_CLS_MERGE_ALIGN_CHECK_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (join_hs && ((s_cls_tuser[0] != s_seg_tuser[0]) ||
                        (s_cls_tlast != s_seg_tlast))) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_misalign = err_q;
`else
    assign err_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_video_dnn_seg_cls_merge.sv
// -----------------------------------------------------------------------------
// tb_video_dnn_seg_cls_merge
//
// Self-checking bench: directed beats on a default instance and on a
// CHANNEL_WIDTH=3 instance, a randomized 640-beat line with random valids and
// random output backpressure scored against a queue-based reference model,
// reset mid-flight, and the optional sideband alignment flag.
// -----------------------------------------------------------------------------
module tb_video_dnn_seg_cls_merge;

    localparam int NC   = 10;
    localparam int CW   = 1;
    localparam int TUW  = 1;
    localparam int NW   = 4;
    localparam int TCW  = 1;
    localparam int CLW  = (NC + 1) * CW;
    localparam int NBEAT = 640;

    logic aclk = 1'b0;
    logic aresetn;

    logic [TUW-1:0]   s_cls_tuser;
    logic             s_cls_tlast;
    logic [NC*CW-1:0] s_cls_tdata;
    logic             s_cls_tvalid;
    logic             s_cls_tready;
    logic [TUW-1:0]   s_seg_tuser;
    logic             s_seg_tlast;
    logic [CW-1:0]    s_seg_tdata;
    logic             s_seg_tvalid;
    logic             s_seg_tready;
    logic [TUW-1:0]   m_tuser;
    logic             m_tlast;
    logic [NW-1:0]    m_tnumber;
    logic [TCW-1:0]   m_tcount;
    logic [CLW-1:0]   m_tclus;
    logic             m_tvalid;
    logic             m_tready;
    logic             err_misalign;

    // CHANNEL_WIDTH=3 instance
    logic        b_cls_tuser, b_cls_tlast, b_cls_tvalid, b_cls_tready;
    logic [29:0] b_cls_tdata;
    logic        b_seg_tuser, b_seg_tlast, b_seg_tvalid, b_seg_tready;
    logic [2:0]  b_seg_tdata;
    logic        b_tuser, b_tlast, b_tvalid, b_tready, b_err;
    logic [3:0]  b_tnumber;
    logic [1:0]  b_tcount;
    logic [32:0] b_tclus;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 aclk = ~aclk;

    video_dnn_seg_cls_merge u_dut (
        .aclk                (aclk),
        .aresetn             (aresetn),
        .s_cls_tuser         (s_cls_tuser),
        .s_cls_tlast         (s_cls_tlast),
        .s_cls_tdata         (s_cls_tdata),
        .s_cls_tvalid        (s_cls_tvalid),
        .s_cls_tready        (s_cls_tready),
        .s_seg_tuser         (s_seg_tuser),
        .s_seg_tlast         (s_seg_tlast),
        .s_seg_tdata         (s_seg_tdata),
        .s_seg_tvalid        (s_seg_tvalid),
        .s_seg_tready        (s_seg_tready),
        .m_axi4s_tuser       (m_tuser),
        .m_axi4s_tlast       (m_tlast),
        .m_axi4s_tnumber     (m_tnumber),
        .m_axi4s_tcount      (m_tcount),
        .m_axi4s_tclustering (m_tclus),
        .m_axi4s_tvalid      (m_tvalid),
        .m_axi4s_tready      (m_tready),
        .err_misalign        (err_misalign)
    );

    video_dnn_seg_cls_merge #(
        .CHANNEL_WIDTH  (3),
        .M_TCOUNT_WIDTH (2)
    ) u_dut3 (
        .aclk                (aclk),
        .aresetn             (aresetn),
        .s_cls_tuser         (b_cls_tuser),
        .s_cls_tlast         (b_cls_tlast),
        .s_cls_tdata         (b_cls_tdata),
        .s_cls_tvalid        (b_cls_tvalid),
        .s_cls_tready        (b_cls_tready),
        .s_seg_tuser         (b_seg_tuser),
        .s_seg_tlast         (b_seg_tlast),
        .s_seg_tdata         (b_seg_tdata),
        .s_seg_tvalid        (b_seg_tvalid),
        .s_seg_tready        (b_seg_tready),
        .m_axi4s_tuser       (b_tuser),
        .m_axi4s_tlast       (b_tlast),
        .m_axi4s_tnumber     (b_tnumber),
        .m_axi4s_tcount      (b_tcount),
        .m_axi4s_tclustering (b_tclus),
        .m_axi4s_tvalid      (b_tvalid),
        .m_axi4s_tready      (b_tready),
        .err_misalign        (b_err)
    );

    typedef struct packed {
        logic [NW-1:0]  num;
        logic [TCW-1:0] cnt;
        logic [CLW-1:0] clu;
        logic           last;
        logic [TUW-1:0] user;
    } beat_t;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: mask each class by the segmentation bits, add background as
    // the inverted mask, count votes, pick the lowest index of the maximum.
    function automatic beat_t ref_beat(input logic [NC*CW-1:0] cls, input logic [CW-1:0] seg,
                                       input logic last, input logic [TUW-1:0] user);
        beat_t b;
        int    best;
        int    bidx;
        int    v;
        b.clu = '0;
        for (int c = 0; c < NC; c++) begin
            b.clu[c*CW +: CW] = cls[c*CW +: CW] & seg;
        end
        b.clu[NC*CW +: CW] = ~seg;
        best = 0;
        bidx = NC;
        for (int c = 0; c <= NC; c++) begin
            v = $countones(b.clu[c*CW +: CW]);
            if (v > best) begin
                best = v;
                bidx = c;
            end
        end
        b.num  = NW'(bidx);
        b.cnt  = (best > (1 << TCW) - 1) ? '1 : TCW'(best);
        b.last = last;
        b.user = user;
        return b;
    endfunction

    // Single directed beat on the default instance; starts and ends 1 time
    // unit after a rising edge, with m_tready held at 1.
    task automatic send_beat(input string tag, input logic [NC*CW-1:0] cls, input logic [CW-1:0] seg,
                             input logic ctlast, input logic stlast,
                             input logic [NW-1:0] enum_, input logic [TCW-1:0] ecnt,
                             input logic [CLW-1:0] eclu);
        s_cls_tdata  = cls;
        s_seg_tdata  = seg;
        s_cls_tlast  = ctlast;
        s_seg_tlast  = stlast;
        s_cls_tuser  = '0;
        s_seg_tuser  = '0;
        s_cls_tvalid = 1'b1;
        s_seg_tvalid = 1'b1;
        @(negedge aclk);
        chk({tag, "_cls_rdy"}, s_cls_tready, 1'b1);
        chk({tag, "_seg_rdy"}, s_seg_tready, 1'b1);
        @(posedge aclk); #1;
        s_cls_tvalid = 1'b0;
        s_seg_tvalid = 1'b0;
        @(negedge aclk);
        chk({tag, "_vld_c1"}, m_tvalid, 1'b0);
        @(negedge aclk);
        chk({tag, "_vld_c2"}, m_tvalid, 1'b1);
        chk({tag, "_num"},  m_tnumber, enum_);
        chk({tag, "_cnt"},  m_tcount,  ecnt);
        chk({tag, "_clu"},  m_tclus,   eclu);
        chk({tag, "_last"}, m_tlast,   ctlast);
        @(posedge aclk); #1;
    endtask

    task automatic send3(input string tag, input logic [29:0] cls, input logic [2:0] seg,
                         input logic [3:0] enum_, input logic [1:0] ecnt, input logic [32:0] eclu);
        b_cls_tdata  = cls;
        b_seg_tdata  = seg;
        b_cls_tvalid = 1'b1;
        b_seg_tvalid = 1'b1;
        @(negedge aclk);
        chk({tag, "_rdy"}, b_cls_tready & b_seg_tready, 1'b1);
        @(posedge aclk); #1;
        b_cls_tvalid = 1'b0;
        b_seg_tvalid = 1'b0;
        @(negedge aclk);
        @(negedge aclk);
        chk({tag, "_vld"}, b_tvalid,  1'b1);
        chk({tag, "_num"}, b_tnumber, enum_);
        chk({tag, "_cnt"}, b_tcount,  ecnt);
        chk({tag, "_clu"}, b_tclus,   eclu);
        @(posedge aclk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [NC*CW-1:0] cls_mem [NBEAT];
        logic [CW-1:0]    seg_mem [NBEAT];
        beat_t            expq [$];
        beat_t            got;
        int nin, nout, occ, cycles, nb;
        logic exp_acc, joined, hold_cls, hold_seg, prev_stall;

        aresetn      = 1'b0;
        s_cls_tuser  = '0; s_cls_tlast = 1'b0; s_cls_tdata = '0; s_cls_tvalid = 1'b0;
        s_seg_tuser  = '0; s_seg_tlast = 1'b0; s_seg_tdata = '0; s_seg_tvalid = 1'b0;
        m_tready     = 1'b0;
        b_cls_tuser  = 1'b0; b_cls_tlast = 1'b0; b_cls_tdata = '0; b_cls_tvalid = 1'b0;
        b_seg_tuser  = 1'b0; b_seg_tlast = 1'b0; b_seg_tdata = '0; b_seg_tvalid = 1'b0;
        b_tready     = 1'b1;

        repeat (2) @(posedge aclk);
        @(negedge aclk);
        chk("rst_vld",  m_tvalid, 1'b0);
        chk("rst_num",  m_tnumber, '0);
        chk("rst_cnt",  m_tcount, '0);
        chk("rst_clu",  m_tclus, '0);
        chk("rst_last", m_tlast, 1'b0);
        chk("rst_err",  err_misalign, 1'b0);
        chk("rst_vld3", b_tvalid, 1'b0);
        @(posedge aclk); #1;
        aresetn  = 1'b1;
        m_tready = 1'b1;

        // Directed beats on the default instance
        send_beat("d_cls5", 10'b0000100000, 1'b1, 1'b0, 1'b0, 4'd5,  1'b1, 11'b000_0010_0000);
        send_beat("d_bg",   10'h3FF,        1'b0, 1'b0, 1'b0, 4'd10, 1'b1, 11'b100_0000_0000);
        send_beat("d_last", 10'h001,        1'b1, 1'b1, 1'b1, 4'd0,  1'b1, 11'h001);

        // Classification valid three cycles ahead of segmentation
        s_cls_tdata  = 10'h008;
        s_seg_tdata  = 1'b1;
        s_cls_tvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            chk("early_cls_rdy", s_cls_tready, 1'b0);
            chk("early_seg_rdy", s_seg_tready, 1'b1);
            chk("early_out_vld", m_tvalid, 1'b0);
            @(posedge aclk); #1;
        end
        s_seg_tvalid = 1'b1;
        @(negedge aclk);
        chk("late_cls_rdy", s_cls_tready, 1'b1);
        @(posedge aclk); #1;
        s_cls_tvalid = 1'b0;
        s_seg_tvalid = 1'b0;
        nb = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            if (m_tvalid) begin
                nb++;
                chk("late_num", m_tnumber, 4'd3);
            end
        end
        chk("late_one_beat", nb, 1);
        @(posedge aclk); #1;

        // Wider-channel instance: tie resolves to lowest index, then background
        send3("w_tie", 30'h00E001C0, 3'b111, 4'd2,  2'd3, 33'h0_00E0_01C0);
        send3("w_bg",  30'h00E001C0, 3'b000, 4'd10, 2'd3, 33'h1_C000_0000);

        // Randomized 640-beat line with random valids and random backpressure
        for (int i = 0; i < NBEAT; i++) begin
            cls_mem[i] = NC'($urandom);
            seg_mem[i] = CW'($urandom);
        end
        nin = 0; nout = 0; occ = 0; cycles = 0;
        hold_cls = 1'b0; hold_seg = 1'b0; prev_stall = 1'b0;
        while (nout < NBEAT && cycles < 20000) begin
            if (nin < NBEAT) begin
                if (!hold_cls) s_cls_tvalid = 1'($urandom_range(0, 1));
                if (!hold_seg) s_seg_tvalid = 1'($urandom_range(0, 1));
            end else begin
                s_cls_tvalid = 1'b0;
                s_seg_tvalid = 1'b0;
            end
            if (nin < NBEAT) begin
                s_cls_tdata = cls_mem[nin];
                s_seg_tdata = seg_mem[nin];
                s_cls_tuser = TUW'(nin == 0);
                s_seg_tuser = TUW'(nin == 0);
                s_cls_tlast = (nin == NBEAT - 1);
                s_seg_tlast = (nin == NBEAT - 1);
            end
            m_tready = 1'($urandom_range(0, 1));
            @(negedge aclk);
            // Two beats fit in flight; beyond that only a draining output frees a slot.
            exp_acc = (occ < 2) || m_tready;
            chk("rnd_cls_rdy", s_cls_tready, s_seg_tvalid && exp_acc);
            chk("rnd_seg_rdy", s_seg_tready, s_cls_tvalid && exp_acc);
            if (prev_stall) chk("rnd_stall_vld", m_tvalid, 1'b1);
            if (m_tvalid) begin
                got = '{num: m_tnumber, cnt: m_tcount, clu: m_tclus, last: m_tlast, user: m_tuser};
                if (expq.size() == 0) begin
                    chk("rnd_spurious", 1'b1, 1'b0);
                end else begin
                    chk($sformatf("rnd_beat%0d", nout), got, expq[0]);
                    if (m_tready) begin
                        void'(expq.pop_front());
                        nout++;
                        occ--;
                    end
                end
            end
            joined = s_cls_tvalid && s_seg_tvalid && exp_acc;
            if (joined) begin
                expq.push_back(ref_beat(cls_mem[nin], seg_mem[nin], nin == NBEAT - 1, TUW'(nin == 0)));
                nin++;
                occ++;
            end
            hold_cls   = s_cls_tvalid && !joined;
            hold_seg   = s_seg_tvalid && !joined;
            prev_stall = m_tvalid && !m_tready;
            @(posedge aclk); #1;
            cycles++;
        end
        chk("rnd_out_count", nout, NBEAT);
        chk("rnd_in_count",  nin,  NBEAT);
        chk("rnd_queue_empty", expq.size(), 0);
        s_cls_tvalid = 1'b0;
        s_seg_tvalid = 1'b0;
        s_cls_tuser  = '0;
        s_seg_tuser  = '0;
        s_cls_tlast  = 1'b0;
        s_seg_tlast  = 1'b0;
        m_tready     = 1'b1;
        repeat (3) @(posedge aclk);
        #1;

        // Reset while a beat is in flight discards it
        s_cls_tdata  = 10'h010;
        s_seg_tdata  = 1'b1;
        s_cls_tvalid = 1'b1;
        s_seg_tvalid = 1'b1;
        @(negedge aclk);
        chk("midrst_join", s_cls_tready, 1'b1);
        @(posedge aclk); #1;
        s_cls_tvalid = 1'b0;
        s_seg_tvalid = 1'b0;
        aresetn      = 1'b0;
        @(posedge aclk); #1;
        aresetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge aclk);
            chk("midrst_vld", m_tvalid, 1'b0);
        end
        @(posedge aclk); #1;

        // Segmentation tlast one beat early
        send_beat("align", 10'h200, 1'b1, 1'b0, 1'b1, 4'd9, 1'b1, 11'h200);
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
`ifdef VIDEO_DNN_SEG_CLS_MERGE_ALIGN_CHECK_EN
            chk("align_err", err_misalign, 1'b1);
`else
            chk("align_err", err_misalign, 1'b0);
`endif
        end
        @(posedge aclk); #1;
        aresetn = 1'b0;
        @(posedge aclk); #1;
        @(negedge aclk);
        chk("final_rst_err", err_misalign, 1'b0);
        chk("final_rst_vld", m_tvalid, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
